chunked_addsub: RTL and testbench

Multi-cycle, parametrised add/subtract unit for the microprocessor datapath. It processes a WIDTH-bit operation in CHUNK-bit slices, one slice per clock, and produces the result with carry, overflow, zero and negative flags. It uses a valid/ready handshake on both input and output so the control unit can stall on it. It replaces the single-cycle combinational adder wherever a wide datapath would otherwise limit clock frequency.

---
 rtl/adder_pkg.sv | 28 ++
 rtl/chunk_adder.sv | 14 +
 rtl/chunked_addsub.sv | 129 ++++++++++++
 tb/tb_chunked_addsub.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the chunked add/subtract unit: FSM states and
// elaboration-time helpers for slice count and slice-index width.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic int unsigned nchunk(input int unsigned width, input int unsigned chunk);
    return width / chunk;
  endfunction

  // Bits needed to index n slices; never less than 1 so a single-slice unit still has an index.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned p;
    r = 1;
    p = 2;
    while (p < n) begin
      p = p * 2;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit adder with carry in and carry out.
module chunk_adder #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/chunked_addsub.sv
// Multi-cycle add/subtract: one CHUNK-bit slice per clock, LSB slice first,
// with valid/ready handshakes on operands and result.
module chunked_addsub
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int unsigned NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int unsigned IW     = clog2(NCHUNK);

  generate
    if ((CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_chunk
      $error("chunked_addsub: WIDTH must be a non-zero multiple of CHUNK");
    end
  endgenerate

  state_t            state;
  logic [WIDTH-1:0]  a_reg;
  logic [WIDTH-1:0]  bx_reg;
  logic [WIDTH-1:0]  acc;
  logic [WIDTH-1:0]  acc_next;
  logic              carry;
  logic [IW-1:0]     idx;
  logic [CHUNK-1:0]  a_sl;
  logic [CHUNK-1:0]  b_sl;
  logic [CHUNK-1:0]  sum;
  logic              c;
  logic              last;

  // Slice mux in front of the single shared adder, and the slice write-back.
  always_comb begin
    a_sl     = '0;
    b_sl     = '0;
    acc_next = acc;
    for (int unsigned i = 0; i < NCHUNK; i++) begin
      if (idx == IW'(i)) begin
        a_sl                        = a_reg[i*CHUNK +: CHUNK];
        b_sl                        = bx_reg[i*CHUNK +: CHUNK];
        acc_next[i*CHUNK +: CHUNK]  = sum;
      end
    end
  end

  assign last = (idx == IW'(NCHUNK - 1));

  chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
    .a    (a_sl),
    .b    (b_sl),
    .cin  (carry),
    .sum  (sum),
    .cout (c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      y         <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
      a_reg     <= '0;
      bx_reg    <= '0;
      acc       <= '0;
      carry     <= 1'b0;
      idx       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_reg    <= a;
            bx_reg   <= sub ? ~b : b;
            carry    <= sub ? 1'b1 : cin;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end else begin
            in_ready <= 1'b1;
          end
        end
        RUN: begin
          acc   <= acc_next;
          carry <= c;
          idx   <= idx + 1'b1;
          // Flags come from the combinational final values so they land with out_valid.
          if (last) begin
            state     <= DONE;
            out_valid <= 1'b1;
            y         <= acc_next;
            cout      <= c;
            ovf       <= (a_reg[WIDTH-1] == bx_reg[WIDTH-1]) &&
                         (acc_next[WIDTH-1] != a_reg[WIDTH-1]);
            zero      <= (acc_next == '0);
            neg       <= acc_next[WIDTH-1];
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chunked_addsub.sv
// Directed self-checking bench for chunked_addsub at 8/4, 32/8 and 32/32.
module tb_chunked_addsub;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] a;
  logic [31:0] b;
  logic        sub;
  logic        cin;
  logic        out_ready;
  logic [2:0]  iv;
  logic [2:0]  ir;
  logic [2:0]  ov;
  logic [2:0]  co;
  logic [2:0]  of;
  logic [2:0]  zr;
  logic [2:0]  ng;
  logic [7:0]  y8;
  logic [31:0] y32a;
  logic [31:0] y32b;
  logic [31:0] yy [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign yy[0] = {24'h0, y8};
  assign yy[1] = y32a;
  assign yy[2] = y32b;

  chunked_addsub #(.WIDTH(8), .CHUNK(4)) u_w8c4 (
    .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]),
    .a(a[7:0]), .b(b[7:0]), .sub(sub), .cin(cin),
    .out_valid(ov[0]), .out_ready(out_ready), .y(y8),
    .cout(co[0]), .ovf(of[0]), .zero(zr[0]), .neg(ng[0])
  );

  chunked_addsub #(.WIDTH(32), .CHUNK(8)) u_w32c8 (
    .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]),
    .a(a), .b(b), .sub(sub), .cin(cin),
    .out_valid(ov[1]), .out_ready(out_ready), .y(y32a),
    .cout(co[1]), .ovf(of[1]), .zero(zr[1]), .neg(ng[1])
  );

  chunked_addsub #(.WIDTH(32), .CHUNK(32)) u_w32c32 (
    .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(ir[2]),
    .a(a), .b(b), .sub(sub), .cin(cin),
    .out_valid(ov[2]), .out_ready(out_ready), .y(y32b),
    .cout(co[2]), .ovf(of[2]), .zero(zr[2]), .neg(ng[2])
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_flags(input string tag, input int sel, input logic [31:0] ey,
                           input logic ec, input logic eo, input logic ez, input logic en);
    chk({tag, ".y"},    yy[sel],  ey);
    chk({tag, ".cout"}, 32'(co[sel]), 32'(ec));
    chk({tag, ".ovf"},  32'(of[sel]), 32'(eo));
    chk({tag, ".zero"}, 32'(zr[sel]), 32'(ez));
    chk({tag, ".neg"},  32'(ng[sel]), 32'(en));
  endtask

  // Accept one operation, scramble the inputs afterwards, wait for the result and check it.
  // With hs set (out_ready high), also check the DONE->IDLE turnaround.
  task automatic run_op(input string tag, input int sel, input logic [31:0] ta, input logic [31:0] tb,
                        input logic ts, input logic tc, input logic [31:0] ey,
                        input logic ec, input logic eo, input logic ez, input logic en,
                        input int elat, input logic hs);
    int n;
    n = 0;
    while (!ir[sel] && n < 50) begin
      tick();
      n++;
    end
    chk({tag, ".in_ready"}, 32'(ir[sel]), 32'd1);
    a = ta; b = tb; sub = ts; cin = tc;
    iv[sel] = 1'b1;
    tick();
    iv[sel] = 1'b0;
    a = ~ta; b = ~tb; sub = ~ts; cin = ~tc;
    chk({tag, ".busy"}, 32'(ir[sel]), 32'd0);
    n = 0;
    while (!ov[sel] && n < 50) begin
      tick();
      n++;
    end
    chk({tag, ".latency"}, n, elat);
    chk_flags(tag, sel, ey, ec, eo, ez, en);
    if (hs) begin
      tick();
      chk({tag, ".ov_drop"}, 32'(ov[sel]), 32'd0);
      chk({tag, ".ir_back"}, 32'(ir[sel]), 32'd1);
      chk_flags({tag, ".held"}, sel, ey, ec, eo, ez, en);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; iv = '0; a = '0; b = '0; sub = 1'b0; cin = 1'b0; out_ready = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst%0d.out_valid", i), 32'(ov[i]), 32'd0);
      chk($sformatf("rst%0d.in_ready", i),  32'(ir[i]), 32'd0);
      chk_flags($sformatf("rst%0d", i), i, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    reset = 1'b0;
    tick();

    run_op("add3c47",  0, 32'h3C, 32'h47, 1'b0, 1'b0, 32'h83, 1'b0, 1'b1, 1'b0, 1'b1, 2, 1'b1);
    run_op("sub1010",  0, 32'h10, 32'h10, 1'b1, 1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 1'b0, 2, 1'b1);
    run_op("sub0507",  0, 32'h05, 32'h07, 1'b1, 1'b0, 32'hFE, 1'b0, 1'b0, 1'b0, 1'b1, 2, 1'b1);
    run_op("addff00c", 0, 32'hFF, 32'h00, 1'b0, 1'b1, 32'h00, 1'b1, 1'b0, 1'b1, 1'b0, 2, 1'b1);

    out_ready = 1'b0;
    run_op("bp", 0, 32'h22, 32'h11, 1'b0, 1'b0, 32'h33, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b0);
    for (int k = 0; k < 5; k++) begin
      a = 32'hA0 + 32'(k); b = 32'h5F; sub = 1'b0; cin = 1'b1;
      iv[0] = 1'b1;
      tick();
      chk($sformatf("bp%0d.out_valid", k), 32'(ov[0]), 32'd1);
      chk($sformatf("bp%0d.in_ready", k),  32'(ir[0]), 32'd0);
      chk_flags($sformatf("bp%0d", k), 0, 32'h33, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    iv[0] = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp.ov_drop", 32'(ov[0]), 32'd0);
    chk("bp.ir_back", 32'(ir[0]), 32'd1);
    run_op("add7f01", 0, 32'h7F, 32'h01, 1'b0, 1'b0, 32'h80, 1'b0, 1'b1, 1'b0, 1'b1, 2, 1'b1);

    a = 32'h12; b = 32'h34; sub = 1'b0; cin = 1'b0;
    iv[0] = 1'b1;
    tick();
    iv[0] = 1'b0;
    tick();
    chk("abort.mid_run_ov", 32'(ov[0]), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort.out_valid", 32'(ov[0]), 32'd0);
    chk("abort.in_ready",  32'(ir[0]), 32'd0);
    chk_flags("abort", 0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("abort.ir_after", 32'(ir[0]), 32'd1);
    run_op("add1234", 0, 32'h12, 32'h34, 1'b0, 1'b0, 32'h46, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b1);

    run_op("w32c8.wrap",  1, 32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 4, 1'b1);
    run_op("w32c8.subov", 1, 32'h80000000, 32'h1, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0, 4, 1'b1);
    run_op("w32c32.wrap", 2, 32'hFFFFFFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
